obi_axil_bridge: RTL and testbench
==================================

# obi_axil_bridge

Bridge between the OBI-style data port of a tile's RISC-V core (req/gnt/rvalid) and an AXI4-Lite manager port toward the MPSoC interconnect. It accepts one core transaction at a time, converts it to AXI4-Lite AW/W/B or AR/R traffic, and returns read data and error status to the core. A programmable response timeout keeps a dead slave from stalling the core forever. It sits directly downstream of the core's data memory interface inside the tile.

## Interface
- ADDR_W, 32, address width (OBI and AXI)
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 1024, cycles allowed in a response-wait state; 0 disables the timeout
- AXPROT, 3'b000, constant driven on awprot/arprot
- core_clk  in  1  clock; all logic on the rising edge
- core_rst  in  1  synchronous, active-high reset
- obi_req_i  in  1  core request
- obi_gnt_o  out  1  request accepted this cycle
- obi_we_i  in  1  1 = write
- obi_be_i  in  DATA_W/8  byte enables
- obi_addr_i  in  ADDR_W  byte address
- obi_wdata_i  in  DATA_W  write data
- obi_rvalid_o  out  1  response valid (one-cycle pulse)
- obi_rdata_o  out  DATA_W  read data; 0 for writes and errors
- obi_err_o  out  1  response error, qualified by obi_rvalid_o
- AXI4-Lite manager: awvalid/awready/awaddr[ADDR_W]/awprot[3], wvalid/wready/wdata[DATA_W]/wstrb[DATA_W/8], bvalid/bready/bresp[2], arvalid/arready/araddr[ADDR_W]/arprot[3], rvalid/rready/rdata[DATA_W]/rresp[2]; standard directions, m_axi_ prefix

## Operation
- States: IDLE, WR, B_WAIT, RD, R_WAIT, RESP, DRAIN.
- IDLE: obi_gnt_o = obi_req_i (combinational). On req&&gnt, register we/be/addr/wdata; go to WR (we=1) or RD (we=0). obi_gnt_o is 0 in every other state.
- WR: awvalid and wvalid both asserted from the first WR cycle; each drops independently after its own handshake; awaddr/wdata/wstrb (= be) stay stable until their handshake. Both handshakes done (same or different cycles) -> B_WAIT.
- B_WAIT: bready=1. On bvalid: err = (bresp != 2'b00), rdata = 0 -> RESP.
- RD: arvalid=1, araddr stable; on arready -> R_WAIT.
- R_WAIT: rready=1. On rvalid: capture rdata (forced to 0 if rresp != OKAY); err = (rresp != 2'b00) -> RESP.
- RESP: obi_rvalid_o=1 for exactly one cycle with registered rdata/err -> IDLE.
- Timeout: counter cleared on entry to B_WAIT/R_WAIT, increments each cycle there. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no response that cycle -> RESP with err=1, rdata=0, then DRAIN instead of IDLE.
- DRAIN: bready (write) or rready (read) held 1; on the late response, discard it -> IDLE. No new grant meanwhile.
- A response arriving in the same cycle the timeout fires takes priority: normal capture, no DRAIN.
- Timeout never applies to WR/RD: AXI valids are never withdrawn before ready.
- OKAY=00 only; EXOKAY/SLVERR/DECERR all report err=1.

## Timing
- Reset (synchronous, core_rst=1 at a clock edge): state IDLE; obi_gnt_o follows req (0 while core_rst=1); obi_rvalid_o, obi_err_o, all AXI valid/ready outputs 0; obi_rdata_o, captured registers, and timeout counter 0. Reset mid-transaction abandons it immediately; no response is issued.
- All AXI outputs and obi_rvalid_o/obi_rdata_o/obi_err_o are registered; obi_gnt_o is the only combinational output.
- Best-case read: accept at cycle 0, arvalid cycle 1 (arready=1), rvalid cycle 2, obi_rvalid_o cycle 3. Best-case write: same, with B in place of R.
- Back-to-back: next grant earliest in the cycle after RESP (one-cycle IDLE gap minimum).
- At most one outstanding transaction.

## Test plan
- Read: req addr 0x1000, arready=1, rvalid next cycle with rdata 0xDEADBEEF, OKAY -> araddr=0x1000, obi_rvalid_o at cycle 3, rdata 0xDEADBEEF, err 0.
- Write with skewed channels: addr 0x2004, wdata 0x12345678, be 4'b0011; wready 3 cycles after awready -> awvalid drops after its handshake, wvalid stays; wstrb 0011; bvalid OKAY -> rvalid, err 0, rdata 0.
- Error responses: rresp=SLVERR on read, bresp=DECERR on write -> err=1, rdata=0 both.
- Timeout: TIMEOUT=8, slave never answers read -> err pulse 8 cycles after R_WAIT entry; gnt stays 0; late rvalid 5 cycles later swallowed, then next req granted.
- Simultaneous: rvalid in the exact timeout cycle -> normal data, err 0, no DRAIN.
- Reset mid-B_WAIT: core_rst high one cycle -> all outputs 0 next cycle, no obi_rvalid_o, fresh read completes normally.

Source files
------------

// File: rtl/obi_axil_bridge.sv
// OBI (req/gnt/rvalid) to AXI4-Lite manager bridge: one transaction in flight,
// with a programmable response timeout that drains the late response.
module obi_axil_bridge #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          TIMEOUT = 1024,
  parameter logic [2:0]  AXPROT  = 3'b000
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic                obi_we_i,
  input  logic [DATA_W/8-1:0] obi_be_i,
  input  logic [ADDR_W-1:0]   obi_addr_i,
  input  logic [DATA_W-1:0]   obi_wdata_i,
  output logic                obi_rvalid_o,
  output logic [DATA_W-1:0]   obi_rdata_o,
  output logic                obi_err_o,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp
);

  localparam int         STRB_W = DATA_W / 8;
  localparam int         CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OKAY   = 2'b00;

  typedef enum logic [2:0] {IDLE, WR, B_WAIT, RD, R_WAIT, RESP, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [STRB_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timed_out_q, timed_out_d;

  logic aw_hs, w_hs, late_rsp, timeout_hit;

  assign aw_hs       = awvalid_q && m_axi_awready;
  assign w_hs        = wvalid_q && m_axi_wready;
  assign late_rsp    = (bready_q && m_axi_bvalid) || (rready_q && m_axi_rvalid);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Grant is the only combinational output; it is suppressed during reset.
  assign obi_gnt_o = (state_q == IDLE) && obi_req_i && !core_rst;

  always_comb begin
    // NOTE: every _d gets a default first, so no branch below can infer a latch.
    state_d     = state_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;

    unique case (state_q)
      IDLE: begin
        if (obi_gnt_o) begin
          be_d        = obi_be_i;
          addr_d      = obi_addr_i;
          wdata_d     = obi_wdata_i;
          timed_out_d = 1'b0;
          if (obi_we_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
          state_d  = B_WAIT;
          bready_d = 1'b1;
          cnt_d    = '0;
        end
      end
      B_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the timeout cycle wins over the timeout.
        if (m_axi_bvalid) begin
          state_d     = RESP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi_bresp != OKAY);
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      RD: begin
        if (m_axi_arready) begin
          state_d   = R_WAIT;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_axi_rvalid) begin
          state_d     = RESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi_rresp != OKAY);
          rsp_rdata_d = (m_axi_rresp == OKAY) ? m_axi_rdata : '0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      RESP: begin
        // After a timeout the ready stays high; a late beat right here skips DRAIN.
        if (timed_out_q && !late_rsp) begin
          state_d = DRAIN;
        end else begin
          state_d     = IDLE;
          bready_d    = 1'b0;
          rready_d    = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      DRAIN: begin
        if (late_rsp) begin
          state_d     = IDLE;
          bready_d    = 1'b0;
          rready_d    = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= IDLE;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign obi_rvalid_o  = rsp_valid_q;
  assign obi_rdata_o   = rsp_rdata_q;
  assign obi_err_o     = rsp_err_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = AXPROT;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = be_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = AXPROT;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_obi_axil_bridge.sv
// Directed bench for obi_axil_bridge: stimulus pushes expected OBI responses
// into a scoreboard that a negedge monitor pops whenever obi_rvalid_o fires.
module tb_obi_axil_bridge;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        obi_req_i, obi_gnt_o, obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_addr_i, obi_wdata_i;
  logic        obi_rvalid_o, obi_err_o;
  logic [31:0] obi_rdata_o;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  obi_axil_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .AXPROT(3'b000)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_we_i(obi_we_i),
    .obi_be_i(obi_be_i), .obi_addr_i(obi_addr_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always @(posedge core_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  // Monitor: every OBI response must match the oldest expectation, including its cycle.
  always @(negedge core_clk) begin
    if (!core_rst && obi_rvalid_o) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {31'd0, obi_rvalid_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", obi_rdata_o, mon_e.rdata);
        check("rsp_err", {31'd0, obi_err_o}, {31'd0, mon_e.err});
        check("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic push(input logic [31:0] rdata, input logic err, input int dcyc);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = acc_cyc + dcyc;
    sb.push_back(e);
  endtask

  // Drive an OBI request, wait (bounded) for the grant, record the accept cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int waits);
    obi_req_i   = 1'b1;
    obi_we_i    = we;
    obi_addr_i  = addr;
    obi_wdata_i = wdata;
    obi_be_i    = be;
    waits = 0;
    @(negedge core_clk);
    while (!obi_gnt_o && waits < 32) begin
      tick();
      waits++;
      @(negedge core_clk);
    end
    acc_cyc = cyc;
    tick();
    obi_req_i = 1'b0;
  endtask

  // Read slave: arready after ar_lat cycles, rvalid r_lat cycles after the AR handshake.
  task automatic rd_slave(input int ar_lat, input int r_lat, input logic [31:0] data,
                          input logic [1:0] resp, input logic [31:0] exp_addr);
    int n = 0;
    while (!m_axi_arvalid && n < 32) begin tick(); n++; end
    check("arvalid", {31'd0, m_axi_arvalid}, 32'd1);
    repeat (ar_lat) tick();
    check("araddr", m_axi_araddr, exp_addr);
    check("arprot", {29'd0, m_axi_arprot}, 32'd0);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    repeat (r_lat) tick();
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
    n = 0;
    while (!m_axi_rready && n < 32) begin tick(); n++; end
    check("rready", {31'd0, m_axi_rready}, 32'd1);
    tick();
    m_axi_rvalid = 1'b0;
  endtask

  // AW/W slave: independent ready latencies counted from the first WR cycle.
  task automatic wr_aw_w(input int aw_lat, input int w_lat, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data, input logic [3:0] exp_be);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit skew_checked = 1'b0;
    for (int c = 0; c < 64 && !(aw_done && w_done); c++) begin
      m_axi_awready = !aw_done && (c >= aw_lat);
      m_axi_wready  = !w_done && (c >= w_lat);
      if (aw_done && !w_done && !skew_checked) begin
        check("aw_drop_w_hold", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd1);
        skew_checked = 1'b1;
      end
      if (m_axi_awready && m_axi_awvalid) begin
        check("awaddr", m_axi_awaddr, exp_addr);
        aw_done = 1'b1;
      end
      if (m_axi_wready && m_axi_wvalid) begin
        check("wdata", m_axi_wdata, exp_data);
        check("wstrb", {28'd0, m_axi_wstrb}, {28'd0, exp_be});
        w_done = 1'b1;
      end
      tick();
    end
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    check("aw_w_done", {30'd0, aw_done, w_done}, 32'd3);
  endtask

  task automatic b_phase(input int b_lat, input logic [1:0] resp);
    int n = 0;
    repeat (b_lat) tick();
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    while (!m_axi_bready && n < 32) begin tick(); n++; end
    check("bready", {31'd0, m_axi_bready}, 32'd1);
    tick();
    m_axi_bvalid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {25'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                 m_axi_rready, obi_rvalid_o, obi_err_o}, 32'd0);
    check({name, "_rdata"}, obi_rdata_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int gnt_hi;
    core_rst = 1'b1;
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_be_i = '0; obi_addr_i = '0; obi_wdata_i = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    repeat (3) tick();
    @(negedge core_clk);
    check("rst_gnt", {31'd0, obi_gnt_o}, 32'd0);
    check_idle_outputs("rst_outputs");
    check("rst_awaddr", m_axi_awaddr, 32'd0);
    obi_req_i = 1'b0;
    tick();
    core_rst = 1'b0;
    tick();

    // Best-case read: response at accept + 3.
    issue(1'b0, 32'h0000_1000, 32'd0, 4'hF, w);
    check("rd_gnt_wait", w, 0);
    push(32'hDEAD_BEEF, 1'b0, 3);
    rd_slave(0, 0, 32'hDEAD_BEEF, 2'b00, 32'h0000_1000);
    repeat (2) tick();

    // Write with W three cycles behind AW; B at once: response at accept + 6.
    issue(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, w);
    push(32'd0, 1'b0, 6);
    wr_aw_w(0, 3, 32'h0000_2004, 32'h1234_5678, 4'b0011);
    b_phase(0, 2'b00);
    repeat (2) tick();

    // SLVERR read: data forced to zero.
    issue(1'b0, 32'h0000_1010, 32'd0, 4'hF, w);
    push(32'd0, 1'b1, 3);
    rd_slave(0, 0, 32'hCAFE_F00D, 2'b10, 32'h0000_1010);
    repeat (2) tick();

    // DECERR write, AW two cycles behind W, B one cycle late: accept + 6.
    issue(1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'b1100, w);
    push(32'd0, 1'b1, 6);
    wr_aw_w(2, 0, 32'h0000_3000, 32'hA5A5_A5A5, 4'b1100);
    b_phase(1, 2'b11);
    repeat (2) tick();

    // Read timeout: R_WAIT entered at accept + 2, error pulse at accept + 10.
    issue(1'b0, 32'h0000_4000, 32'd0, 4'hF, w);
    push(32'd0, 1'b1, 10);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_4400;
    gnt_hi = 0;
    repeat (13) begin
      if (obi_gnt_o) gnt_hi++;
      tick();
    end
    check("to_no_gnt", gnt_hi, 0);
    check("drain_rready", {31'd0, m_axi_rready}, 32'd1);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0BAD_0BAD; m_axi_rresp = 2'b00;
    tick();
    m_axi_rvalid = 1'b0;
    issue(1'b0, 32'h0000_4400, 32'd0, 4'hF, w);
    check("post_drain_gnt_wait", w, 0);
    push(32'h0000_4444, 1'b0, 3);
    rd_slave(0, 0, 32'h0000_4444, 2'b00, 32'h0000_4400);
    repeat (2) tick();

    // Response in the exact timeout cycle wins; no DRAIN, so next grant after one gap.
    issue(1'b0, 32'h0000_5000, 32'd0, 4'hF, w);
    push(32'h55AA_55AA, 1'b0, 10);
    rd_slave(0, 7, 32'h55AA_55AA, 2'b00, 32'h0000_5000);
    issue(1'b1, 32'h0000_6000, 32'hFEED_FACE, 4'hF, w);
    check("b2b_gnt_wait", w, 1);
    push(32'd0, 1'b0, 3);
    wr_aw_w(0, 0, 32'h0000_6000, 32'hFEED_FACE, 4'hF);
    b_phase(0, 2'b00);
    repeat (2) tick();

    // Reset while in B_WAIT: no response, all outputs cleared, fresh read works.
    issue(1'b1, 32'h0000_8000, 32'h1111_2222, 4'hF, w);
    wr_aw_w(0, 0, 32'h0000_8000, 32'h1111_2222, 4'hF);
    tick();
    check("bwait_bready", {31'd0, m_axi_bready}, 32'd1);
    core_rst = 1'b1;
    obi_req_i = 1'b1;
    @(negedge core_clk);
    check("rst_mid_gnt", {31'd0, obi_gnt_o}, 32'd0);
    tick();
    core_rst = 1'b0;
    obi_req_i = 1'b0;
    @(negedge core_clk);
    check_idle_outputs("rst_mid_outputs");
    tick();
    issue(1'b0, 32'h0000_7000, 32'd0, 4'hF, w);
    check("post_rst_gnt_wait", w, 0);
    push(32'h7777_0000, 1'b0, 3);
    rd_slave(0, 0, 32'h7777_0000, 2'b00, 32'h0000_7000);
    repeat (4) tick();

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
